loadable_down_counter: RTL and testbench

//  Synchronous, loadable WIDTH-bit down counter/timer; counterpart to the ripple up-counter.

---
 rtl/loadable_down_counter_if.sv | 25 ++
 rtl/loadable_down_counter.sv | 107 ++++++++++
 tb/tb_loadable_down_counter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/loadable_down_counter_if.sv
// Control/status bundle for the loadable down counter.
// The master drives commands and the load value; the slave (the counter) returns the count and flags.
interface loadable_down_counter_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             en;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output load, load_val, start, stop, en,
        input  q, busy, tc, done
    );

    modport slave (
        input  load, load_val, start, stop, en,
        output q, busy, tc, done
    );
endinterface

// File: rtl/loadable_down_counter.sv
// Loadable WIDTH-bit down counter/timer with a registered terminal-count pulse.
// It either stops in DONE at zero or, with AUTO_RELOAD, reloads from the last loaded value.
module loadable_down_counter #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    loadable_down_counter_if.slave        bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_qNext;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reloadNext;
    logic             r_tc;
    logic             w_tcNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_q      <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_q      <= w_qNext;
            r_reload <= w_reloadNext;
            r_tc     <= w_tcNext;
        end
    end

    // Priority on every edge is load, then stop, then start, then count.
    always_comb begin
        w_stateNext  = r_state;
        w_qNext      = r_q;
        w_reloadNext = r_reload;
        w_tcNext     = 1'b0;

        unique case (r_state)
            IDLE, DONE: begin
                if (bus.load) begin
                    w_qNext      = bus.load_val;
                    w_reloadNext = bus.load_val;
                    w_stateNext  = IDLE;
                end else if (bus.stop) begin
                    w_stateNext = IDLE;
                end else if (bus.start) begin
                    if (r_q != '0) begin
                        w_stateNext = RUN;
                    end else begin
                        // Starting at zero is an immediate terminal count.
                        w_tcNext = 1'b1;
                        if (AUTO_RELOAD) begin
                            w_stateNext = RUN;
                            w_qNext     = r_reload;
                        end else begin
                            w_stateNext = DONE;
                        end
                    end
                end
            end

            RUN: begin
                if (bus.load) begin
                    w_qNext      = bus.load_val;
                    w_reloadNext = bus.load_val;
                end else if (bus.stop) begin
                    w_stateNext = IDLE;
                end else if (bus.en) begin
                    if (r_q > WIDTH'(1)) begin
                        w_qNext = r_q - WIDTH'(1);
                    end else if (r_q == WIDTH'(1)) begin
                        w_qNext  = '0;
                        w_tcNext = 1'b1;
                        if (!AUTO_RELOAD) begin
                            w_stateNext = DONE;
                        end
                    end else if (AUTO_RELOAD) begin
                        w_qNext  = r_reload;
                        w_tcNext = (r_reload == '0);
                    end else begin
                        // Zero was loaded while running: finish rather than wrap.
                        w_tcNext    = 1'b1;
                        w_stateNext = DONE;
                    end
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign bus.q    = r_q;
    assign bus.tc   = r_tc;
    assign bus.busy = (r_state == RUN);
    assign bus.done = (r_state == DONE);
endmodule

// File: tb/tb_loadable_down_counter.sv
// Directed bench for the down counter: a one-shot instance and an auto-reload instance
// driven side by side from one clock and reset, with hand-computed expected values.
module tb_loadable_down_counter;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    loadable_down_counter_if #(.WIDTH(4)) ifOne ();
    loadable_down_counter_if #(.WIDTH(4)) ifAuto ();

    loadable_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dutOne (
        .clk   (clk),
        .reset (reset),
        .bus   (ifOne.slave)
    );

    loadable_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dutAuto (
        .clk   (clk),
        .reset (reset),
        .bus   (ifAuto.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] enPattern [8];
        logic [3:0] expQ3     [8];
        logic       expTc3    [8];
        logic [3:0] expQAuto  [6];
        logic       expTcAuto [6];

        total = 0;
        bad   = 0;
        enPattern = '{1, 0, 1, 0, 1, 0, 1, 0};
        expQ3     = '{3, 3, 2, 2, 1, 1, 0, 0};
        expTc3    = '{0, 0, 0, 0, 0, 0, 1, 0};
        expQAuto  = '{1, 0, 2, 1, 0, 2};
        expTcAuto = '{0, 1, 0, 0, 1, 0};

        reset = 1'b1;
        {ifOne.load, ifOne.start, ifOne.stop, ifOne.en} = 4'b0;
        {ifAuto.load, ifAuto.start, ifAuto.stop, ifAuto.en} = 4'b0;
        ifOne.load_val  = 4'd0;
        ifAuto.load_val = 4'd0;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_q", ifOne.q, 0);
        checkOutput("rst_busy", ifOne.busy, 0);
        checkOutput("rst_done", ifOne.done, 0);
        reset = 1'b0;

        // Asynchronous reset while running at q=5
        ifOne.load = 1'b1; ifOne.load_val = 4'd5;
        applyStimulus();
        ifOne.load = 1'b0; ifOne.start = 1'b1;
        applyStimulus();
        ifOne.start = 1'b0;
        checkOutput("run5_busy", ifOne.busy, 1);
        checkOutput("run5_q", ifOne.q, 5);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_q", ifOne.q, 0);
        checkOutput("async_busy", ifOne.busy, 0);
        checkOutput("async_tc", ifOne.tc, 0);
        checkOutput("async_done", ifOne.done, 0);
        #1 reset = 1'b0;

        // One-shot count from 3
        ifOne.load = 1'b1; ifOne.load_val = 4'd3;
        applyStimulus();
        ifOne.load = 1'b0; ifOne.start = 1'b1; ifOne.en = 1'b1;
        applyStimulus();
        ifOne.start = 1'b0;
        checkOutput("os_q3", ifOne.q, 3);
        checkOutput("os_busy", ifOne.busy, 1);
        applyStimulus();
        checkOutput("os_q2", ifOne.q, 2);
        checkOutput("os_tc2", ifOne.tc, 0);
        applyStimulus();
        checkOutput("os_q1", ifOne.q, 1);
        applyStimulus();
        checkOutput("os_q0", ifOne.q, 0);
        checkOutput("os_tc", ifOne.tc, 1);
        checkOutput("os_done", ifOne.done, 1);
        checkOutput("os_busy0", ifOne.busy, 0);
        applyStimulus();
        checkOutput("os_tc_clr", ifOne.tc, 0);
        checkOutput("os_hold_q", ifOne.q, 0);
        checkOutput("os_hold_done", ifOne.done, 1);

        // Enable gating from 4
        ifOne.en = 1'b0; ifOne.load = 1'b1; ifOne.load_val = 4'd4;
        applyStimulus();
        checkOutput("gate_load_q", ifOne.q, 4);
        checkOutput("gate_load_done", ifOne.done, 0);
        ifOne.load = 1'b0; ifOne.start = 1'b1;
        applyStimulus();
        ifOne.start = 1'b0;
        checkOutput("gate_start_q", ifOne.q, 4);
        for (int i = 0; i < 8; i++) begin
            ifOne.en = enPattern[i][0];
            applyStimulus();
            checkOutput($sformatf("gate_q_%0d", i), ifOne.q, expQ3[i]);
            checkOutput($sformatf("gate_tc_%0d", i), ifOne.tc, expTc3[i]);
        end
        ifOne.en = 1'b0;

        // Start with q=0: single tc, DONE, no wrap
        ifOne.stop = 1'b1;
        applyStimulus();
        ifOne.stop = 1'b0;
        checkOutput("z_idle_done", ifOne.done, 0);
        ifOne.start = 1'b1; ifOne.en = 1'b1;
        applyStimulus();
        ifOne.start = 1'b0;
        checkOutput("z_tc", ifOne.tc, 1);
        checkOutput("z_done", ifOne.done, 1);
        checkOutput("z_q", ifOne.q, 0);
        applyStimulus();
        checkOutput("z_tc_clr", ifOne.tc, 0);
        checkOutput("z_nowrap", ifOne.q, 0);

        // Full-range count from 15
        ifOne.load = 1'b1; ifOne.load_val = 4'd15;
        applyStimulus();
        ifOne.load = 1'b0; ifOne.start = 1'b1;
        applyStimulus();
        ifOne.start = 1'b0;
        checkOutput("f_q15", ifOne.q, 15);
        for (int i = 14; i >= 0; i--) begin
            applyStimulus();
            checkOutput($sformatf("f_q_%0d", i), ifOne.q, i);
            checkOutput($sformatf("f_tc_%0d", i), ifOne.tc, (i == 0) ? 1 : 0);
        end
        ifOne.en = 1'b0;

        // Load and start on the same edge: load wins
        ifOne.stop = 1'b1;
        applyStimulus();
        ifOne.stop = 1'b0;
        ifOne.load = 1'b1; ifOne.start = 1'b1; ifOne.load_val = 4'd7;
        applyStimulus();
        ifOne.load = 1'b0; ifOne.start = 1'b0;
        checkOutput("ls_q", ifOne.q, 7);
        checkOutput("ls_busy", ifOne.busy, 0);

        // Abort at 6, resume, reload mid-run
        ifOne.load = 1'b1; ifOne.load_val = 4'd8;
        applyStimulus();
        ifOne.load = 1'b0; ifOne.start = 1'b1; ifOne.en = 1'b1;
        applyStimulus();
        ifOne.start = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("ab_q6", ifOne.q, 6);
        ifOne.stop = 1'b1;
        applyStimulus();
        ifOne.stop = 1'b0;
        checkOutput("ab_busy", ifOne.busy, 0);
        checkOutput("ab_hold", ifOne.q, 6);
        applyStimulus();
        checkOutput("ab_idle_hold", ifOne.q, 6);
        ifOne.start = 1'b1;
        applyStimulus();
        ifOne.start = 1'b0;
        checkOutput("ab_resume_q", ifOne.q, 6);
        checkOutput("ab_resume_busy", ifOne.busy, 1);
        applyStimulus();
        checkOutput("ab_resume_q5", ifOne.q, 5);
        ifOne.load = 1'b1; ifOne.load_val = 4'd9;
        applyStimulus();
        ifOne.load = 1'b0;
        checkOutput("rl_q", ifOne.q, 9);
        checkOutput("rl_busy", ifOne.busy, 1);
        checkOutput("rl_tc", ifOne.tc, 0);
        applyStimulus();
        checkOutput("rl_next_q", ifOne.q, 8);
        ifOne.en = 1'b0;

        // Auto-reload with period 3
        ifAuto.load = 1'b1; ifAuto.load_val = 4'd2;
        applyStimulus();
        ifAuto.load = 1'b0; ifAuto.start = 1'b1; ifAuto.en = 1'b1;
        applyStimulus();
        ifAuto.start = 1'b0;
        checkOutput("ar_q2", ifAuto.q, 2);
        checkOutput("ar_busy", ifAuto.busy, 1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkOutput($sformatf("ar_q_%0d", i), ifAuto.q, expQAuto[i]);
            checkOutput($sformatf("ar_tc_%0d", i), ifAuto.tc, expTcAuto[i]);
            checkOutput($sformatf("ar_done_%0d", i), ifAuto.done, 0);
        end

        // Reload value of zero: tc on every enabled cycle
        ifAuto.load = 1'b1; ifAuto.load_val = 4'd0;
        applyStimulus();
        ifAuto.load = 1'b0;
        checkOutput("ar0_load_tc", ifAuto.tc, 0);
        checkOutput("ar0_load_q", ifAuto.q, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput($sformatf("ar0_tc_%0d", i), ifAuto.tc, 1);
            checkOutput($sformatf("ar0_busy_%0d", i), ifAuto.busy, 1);
            checkOutput($sformatf("ar0_q_%0d", i), ifAuto.q, 0);
        end
        ifAuto.en = 1'b0;
        applyStimulus();
        checkOutput("ar0_gated_tc", ifAuto.tc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
